f3_game_ctrl: RTL and testbench
===============================

# f3_game_ctrl

Sequencing controller for the function-3 sliding-tile puzzle. It consumes the decoded key command (`instruction` code) and the `scramble` level from the function-3 key processor. It owns the board state and executes one blank-tile move per new command. It runs an LFSR-driven scramble sequence and exposes a read port plus status for the VGA renderer.

## Interface
- `GRID`, 4: board edge length; cells = GRID*GRID (must be ≤ 16 and ≥ 2).
- `SCRAMBLE_MOVES`, 64: random moves per scramble (1..65535).
- `LFSR_SEED`, 16'hACE1: LFSR reset value (non-zero).
- Clock/reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `instruction`  in  4  0 none, 1 North, 2 East, 3 West, 4 South, 5 Restart, 6–15 treated as none.
- `scramble`  in  1  scramble key level.
- `tile_rd_addr`  in  4  cell index, row-major, 0 = top-left.
- `tile_rd_data`  out  4  tile value at `tile_rd_addr` (combinational read); out-of-range address reads 0.
- `blank_pos`  out  4  cell index of the blank.
- `move_count`  out  16  user moves since last restart/scramble, saturating.
- `solved`  out  1  board equals solved pattern (registered).
- `busy`  out  1  scramble in progress.

## Operation
- Tile encoding: 0 = blank. Solved board: cell i holds i+1 for i < N-1; cell N-1 holds 0.
- Reset values: board solved, `blank_pos`=N-1, `move_count`=0, `solved`=1, `busy`=0, LFSR=LFSR_SEED, state IDLE, previous-command registers = 0.
- Command detection:
  - A command is "new" when `instruction` ≠ 0 this cycle and the registered previous `instruction` = 0.
  - A scramble request is a 0→1 edge of `scramble`.
  - Held keys produce exactly one action.
- Direction moves the blank:
  - North: row-1.
  - South: row+1.
  - West: col-1.
  - East: col+1.
  - Legal move: swap the blank with the target cell, update `blank_pos`, increment `move_count` (saturate at 16'hFFFF).
  - Illegal (edge) move: no change at all, count unchanged.
- States: IDLE, SCRAMBLE.
- IDLE priority when events coincide: Restart > scramble edge > direction move.
- Restart (any state): board solved, `blank_pos`=N-1, `move_count`=0, state→IDLE, `busy`=0.
- Entering SCRAMBLE: load the iteration counter with SCRAMBLE_MOVES and set `busy`=1.
- Each SCRAMBLE cycle performs one move:
  - Direction = LFSR[1:0] (0 N, 1 E, 2 W, 3 S).
  - If that move is illegal, use the opposite direction, which is always legal for GRID ≥ 2.
  - Decrement the counter.
- Leaving SCRAMBLE: when the counter reaches 0 after the last move, go to IDLE, set `busy`=0, clear `move_count` to 0.
- During SCRAMBLE: direction commands and scramble edges are ignored, but still update the previous-value registers. Restart aborts the scramble.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Advances every clock in every state, so the seed depends on user timing.
  - Never reaches zero.

## Timing
- Direction/restart is registered on the clock edge where the new command is sampled. Board, `blank_pos` and `move_count` are valid the following cycle.
- `solved` is recomputed from the registered board, so it lags the board by one cycle.
- Scramble:
  - Edge sampled at edge k → `busy`=1 from k.
  - Moves occur at edges k+1 … k+SCRAMBLE_MOVES.
  - `busy`=0 and `move_count`=0 after edge k+SCRAMBLE_MOVES.
- `tile_rd_data` is combinational from the board registers; renderer sees updates the cycle after a move.
- Reset asserted mid-scramble or mid-move: immediate return to reset values. No partial swap survives.

## Structure
- Shared package `f3_pkg`:
  - Instruction code localparams (INS_NONE, INS_NORTH, INS_EAST, INS_WEST, INS_SOUTH, INS_RESTART), shared with the key processor.
  - Direction encoding.
  - State enum.
- Sub-module `f3_lfsr`: 16-bit Galois LFSR with SEED parameter, always-enabled, async active-low reset.
- Move legality and target-index computation is a combinational function inside `f3_game_ctrl`, shared by user and scramble paths.

## Test plan
- Reset → all 16 reads give 1..15,0; `blank_pos`=15, `move_count`=0, `solved`=1, `busy`=0.
- From reset, `instruction`=2 (East, illegal) for 1 cycle → board unchanged, `move_count`=0, `solved`=1.
- From reset, `instruction`=3 held 10 cycles → one move only: cell14=0, cell15=15, `blank_pos`=14, `move_count`=1, `solved`=0 one cycle after board change.
- Pulse `scramble` → `busy` high exactly 64 cycles. Afterwards the board is a permutation of 0..15, tile 0 sits at `blank_pos`, and `move_count`=0.
- Assert `instruction`=5 at scramble cycle 20 → next cycle `busy`=0, board solved, `move_count`=0. Same cycle with `scramble` edge and `instruction`=5 from IDLE → restart wins, no scramble.
- Force `move_count` to 16'hFFFE via 65534 legal alternating W/E moves, then two more legal moves → `move_count` holds 16'hFFFF.

Source files
------------

// File: rtl/f3_pkg.sv
// Shared definitions for the function-3 puzzle: key command codes, move
// directions, controller states and the LFSR polynomial.
package f3_pkg;

  localparam logic [3:0] INS_NONE    = 4'd0;
  localparam logic [3:0] INS_NORTH   = 4'd1;
  localparam logic [3:0] INS_EAST    = 4'd2;
  localparam logic [3:0] INS_WEST    = 4'd3;
  localparam logic [3:0] INS_SOUTH   = 4'd4;
  localparam logic [3:0] INS_RESTART = 4'd5;

  // Opposite directions are bitwise complements (N<->S, E<->W).
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_W = 2'd2;
  localparam logic [1:0] DIR_S = 2'd3;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_SCRAMBLE = 1'b1;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic       legal;
    logic [3:0] target;
  } move_t;

  function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
    return ~dir;
  endfunction

endpackage

// File: rtl/f3_lfsr.sv
// Free-running 16-bit Galois LFSR; a non-zero seed keeps it off the all-zero
// lock-up state forever.
module f3_lfsr
  import f3_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else begin
      state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/f3_game_ctrl.sv
// Sliding-tile board owner: one blank move per new key command, LFSR-driven
// scramble sequence, combinational tile read port for the renderer.
module f3_game_ctrl
  import f3_pkg::*;
#(
  parameter int          GRID           = 4,
  parameter int          SCRAMBLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  instruction,
  input  logic        scramble,
  input  logic [3:0]  tile_rd_addr,
  output logic [3:0]  tile_rd_data,
  output logic [3:0]  blank_pos,
  output logic [15:0] move_count,
  output logic        solved,
  output logic        busy
);

  localparam int N = GRID * GRID;

  logic [3:0]  board [N];
  logic [3:0]  blank_q;
  logic [15:0] mcnt;
  logic        solved_q;
  logic [0:0]  state;
  logic [15:0] iter;
  logic [3:0]  prev_ins;
  logic        prev_scr;
  logic [15:0] lfsr;

  f3_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .state (lfsr)
  );

  // Target cell for moving the blank at pos one step in dir; edges are illegal.
  function automatic move_t move_target(input logic [3:0] pos, input logic [1:0] dir);
    int    row;
    int    col;
    move_t m;
    row      = int'(pos) / GRID;
    col      = int'(pos) % GRID;
    m.legal  = 1'b0;
    m.target = pos;
    case (dir)
      DIR_N: if (row > 0) begin
        m.legal  = 1'b1;
        m.target = 4'(int'(pos) - GRID);
      end
      DIR_S: if (row < GRID - 1) begin
        m.legal  = 1'b1;
        m.target = 4'(int'(pos) + GRID);
      end
      DIR_W: if (col > 0) begin
        m.legal  = 1'b1;
        m.target = 4'(int'(pos) - 1);
      end
      default: if (col < GRID - 1) begin
        m.legal  = 1'b1;
        m.target = 4'(int'(pos) + 1);
      end
    endcase
    return m;
  endfunction

  logic       new_cmd;
  logic       scr_edge;
  logic       is_restart;
  logic       user_dir_vld;
  logic [1:0] user_dir;
  move_t      user_mv;
  move_t      scr_try;
  move_t      scr_mv;
  logic       do_swap;
  logic [3:0] swap_tgt;
  logic       board_is_solved;

  always_comb begin
    new_cmd      = (instruction != INS_NONE) && (prev_ins == INS_NONE);
    scr_edge     = scramble && !prev_scr;
    is_restart   = new_cmd && (instruction == INS_RESTART);
    user_dir_vld = new_cmd;
    user_dir     = DIR_N;
    case (instruction)
      INS_NORTH: user_dir = DIR_N;
      INS_EAST:  user_dir = DIR_E;
      INS_WEST:  user_dir = DIR_W;
      INS_SOUTH: user_dir = DIR_S;
      default:   user_dir_vld = 1'b0;
    endcase

    user_mv = move_target(blank_q, user_dir);
    scr_try = move_target(blank_q, lfsr[1:0]);
    scr_mv  = scr_try.legal ? scr_try : move_target(blank_q, opposite_dir(lfsr[1:0]));

    do_swap  = 1'b0;
    swap_tgt = blank_q;
    if (!is_restart) begin
      if (state == ST_SCRAMBLE) begin
        do_swap  = 1'b1;
        swap_tgt = scr_mv.target;
      end else if (!scr_edge && user_dir_vld && user_mv.legal) begin
        do_swap  = 1'b1;
        swap_tgt = user_mv.target;
      end
    end
  end

  always_comb begin
    board_is_solved = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (board[i] != ((i == N - 1) ? 4'd0 : 4'(i + 1))) board_is_solved = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) board[i] <= (i == N - 1) ? 4'd0 : 4'(i + 1);
      blank_q  <= 4'(N - 1);
      mcnt     <= 16'd0;
      solved_q <= 1'b1;
      state    <= ST_IDLE;
      iter     <= 16'd0;
      prev_ins <= INS_NONE;
      prev_scr <= 1'b0;
    end else begin
      prev_ins <= instruction;
      prev_scr <= scramble;
      solved_q <= board_is_solved;
      if (is_restart) begin
        for (int i = 0; i < N; i++) board[i] <= (i == N - 1) ? 4'd0 : 4'(i + 1);
        blank_q <= 4'(N - 1);
        mcnt    <= 16'd0;
        state   <= ST_IDLE;
        iter    <= 16'd0;
      end else begin
        if (do_swap) begin
          board[blank_q]  <= board[swap_tgt];
          board[swap_tgt] <= 4'd0;
          blank_q         <= swap_tgt;
        end
        if (state == ST_IDLE) begin
          if (scr_edge) begin
            state <= ST_SCRAMBLE;
            iter  <= 16'(SCRAMBLE_MOVES);
          end else if (do_swap && mcnt != 16'hFFFF) begin
            mcnt <= mcnt + 16'd1;
          end
        end else begin
          // Scramble moves are not user moves; the count is cleared on exit.
          iter <= iter - 16'd1;
          if (iter == 16'd1) begin
            state <= ST_IDLE;
            mcnt  <= 16'd0;
          end
        end
      end
    end
  end

  assign tile_rd_data = (int'(tile_rd_addr) < N) ? board[tile_rd_addr] : 4'd0;
  assign blank_pos    = blank_q;
  assign move_count   = mcnt;
  assign solved       = solved_q;
  assign busy         = (state == ST_SCRAMBLE);

endmodule

// File: tb/tb_f3_game_ctrl.sv
// Directed bench for f3_game_ctrl: reset state, user moves, held keys,
// scramble length/abort, restart priority, count saturation, async reset.
`timescale 1ns/100ps
module tb_f3_game_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  instruction;
  logic        scramble;
  logic [3:0]  tile_rd_addr;
  logic [3:0]  tile_rd_data;
  logic [3:0]  blank_pos;
  logic [15:0] move_count;
  logic        solved;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0][3:0] solved_pat;
  logic [15:0][3:0] brd;

  f3_game_ctrl #(.GRID(4), .SCRAMBLE_MOVES(64), .LFSR_SEED(16'hACE1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .scramble     (scramble),
    .tile_rd_addr (tile_rd_addr),
    .tile_rd_data (tile_rd_data),
    .blank_pos    (blank_pos),
    .move_count   (move_count),
    .solved       (solved),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic read_board(output logic [15:0][3:0] b);
    for (int i = 0; i < 16; i++) begin
      tile_rd_addr = 4'(i);
      #0.2;
      b[i] = tile_rd_data;
    end
  endtask

  task automatic pulse(input logic [3:0] c);
    @(negedge clk) instruction = c;
    @(negedge clk) instruction = 4'd0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) solved_pat[i] = (i == 15) ? 4'd0 : 4'(i + 1);
    rst_n = 1'b0; instruction = 4'd0; scramble = 1'b0; tile_rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    read_board(brd);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (brd[i] !== solved_pat[i]) begin
        errors++; $display("FAIL reset_cell%0d: got %0d expected %0d", i, brd[i], solved_pat[i]);
      end
    end
    checks++; if (blank_pos !== 4'd15) begin errors++; $display("FAIL reset_blank: got %0d expected 15", blank_pos); end
    checks++; if (move_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", move_count); end
    checks++; if (solved !== 1'b1) begin errors++; $display("FAIL reset_solved: got %b expected 1", solved); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_illegal_east;
    pulse(4'd2);
    @(negedge clk);
    read_board(brd);
    checks++; if (brd !== solved_pat) begin errors++; $display("FAIL east_edge_board: got %h expected %h", brd, solved_pat); end
    checks++; if (blank_pos !== 4'd15) begin errors++; $display("FAIL east_edge_blank: got %0d expected 15", blank_pos); end
    checks++; if (move_count !== 16'd0) begin errors++; $display("FAIL east_edge_count: got %0d expected 0", move_count); end
    checks++; if (solved !== 1'b1) begin errors++; $display("FAIL east_edge_solved: got %b expected 1", solved); end
  endtask

  task automatic test_held_west;
    @(negedge clk) instruction = 4'd3;
    @(negedge clk);
    tile_rd_addr = 4'd14; #0.2;
    checks++; if (tile_rd_data !== 4'd0) begin errors++; $display("FAIL west_cell14: got %0d expected 0", tile_rd_data); end
    tile_rd_addr = 4'd15; #0.2;
    checks++; if (tile_rd_data !== 4'd15) begin errors++; $display("FAIL west_cell15: got %0d expected 15", tile_rd_data); end
    checks++; if (solved !== 1'b1) begin errors++; $display("FAIL west_solved_lag: got %b expected 1", solved); end
    @(negedge clk);
    checks++; if (solved !== 1'b0) begin errors++; $display("FAIL west_solved: got %b expected 0", solved); end
    repeat (8) @(negedge clk);
    instruction = 4'd0;
    checks++; if (blank_pos !== 4'd14) begin errors++; $display("FAIL west_held_blank: got %0d expected 14", blank_pos); end
    checks++; if (move_count !== 16'd1) begin errors++; $display("FAIL west_held_count: got %0d expected 1", move_count); end
  endtask

  task automatic test_restart;
    pulse(4'd5);
    read_board(brd);
    checks++; if (brd !== solved_pat) begin errors++; $display("FAIL restart_board: got %h expected %h", brd, solved_pat); end
    checks++; if (blank_pos !== 4'd15) begin errors++; $display("FAIL restart_blank: got %0d expected 15", blank_pos); end
    checks++; if (move_count !== 16'd0) begin errors++; $display("FAIL restart_count: got %0d expected 0", move_count); end
    @(negedge clk);
    checks++; if (solved !== 1'b1) begin errors++; $display("FAIL restart_solved: got %b expected 1", solved); end
  endtask

  task automatic test_directions;
    logic [15:0][3:0] exp_b;
    exp_b = solved_pat;
    exp_b[10] = 4'd15; exp_b[11] = 4'd11; exp_b[14] = 4'd12; exp_b[15] = 4'd0;
    pulse(4'd1);
    checks++; if (blank_pos !== 4'd11) begin errors++; $display("FAIL north_blank: got %0d expected 11", blank_pos); end
    pulse(4'd3);
    checks++; if (blank_pos !== 4'd10) begin errors++; $display("FAIL west_blank: got %0d expected 10", blank_pos); end
    pulse(4'd4);
    checks++; if (blank_pos !== 4'd14) begin errors++; $display("FAIL south_blank: got %0d expected 14", blank_pos); end
    pulse(4'd2);
    checks++; if (blank_pos !== 4'd15) begin errors++; $display("FAIL east_blank: got %0d expected 15", blank_pos); end
    read_board(brd);
    checks++; if (brd !== exp_b) begin errors++; $display("FAIL dir_board: got %h expected %h", brd, exp_b); end
    checks++; if (move_count !== 16'd4) begin errors++; $display("FAIL dir_count: got %0d expected 4", move_count); end
    @(negedge clk);
    checks++; if (solved !== 1'b0) begin errors++; $display("FAIL dir_solved: got %b expected 0", solved); end
    pulse(4'd6);
    checks++; if (move_count !== 16'd4) begin errors++; $display("FAIL code6_count: got %0d expected 4", move_count); end
  endtask

  task automatic test_scramble;
    int   cyc;
    logic done;
    logic [15:0] seen;
    logic [3:0]  bp;
    pulse(4'd3);
    cyc = 0; done = 1'b0;
    @(negedge clk) scramble = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (t == 3) scramble = 1'b0;
      if (busy) cyc++;
      else if (cyc > 0) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL scramble_timeout: busy cycles %0d, never finished", cyc); end
    checks++; if (cyc != 64) begin errors++; $display("FAIL scramble_len: got %0d expected 64", cyc); end
    read_board(brd);
    seen = 16'h0;
    for (int i = 0; i < 16; i++) seen[brd[i]] = 1'b1;
    checks++; if (seen !== 16'hFFFF) begin errors++; $display("FAIL scramble_perm: got %h expected ffff", seen); end
    bp = blank_pos;
    checks++; if (brd[bp] !== 4'd0) begin errors++; $display("FAIL scramble_blank: cell %0d holds %0d expected 0", bp, brd[bp]); end
    checks++; if (move_count !== 16'd0) begin errors++; $display("FAIL scramble_count: got %0d expected 0", move_count); end
  endtask

  task automatic test_scramble_abort;
    pulse(4'd5);
    @(negedge clk) scramble = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    instruction = 4'd5;
    @(negedge clk);
    instruction = 4'd0; scramble = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (move_count !== 16'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", move_count); end
    read_board(brd);
    checks++; if (brd !== solved_pat) begin errors++; $display("FAIL abort_board: got %h expected %h", brd, solved_pat); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b expected 0", busy); end
  endtask

  task automatic test_restart_beats_scramble;
    pulse(4'd3);
    @(negedge clk) begin instruction = 4'd5; scramble = 1'b1; end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_busy: got %b expected 0", busy); end
    checks++; if (blank_pos !== 4'd15) begin errors++; $display("FAIL prio_blank: got %0d expected 15", blank_pos); end
    checks++; if (move_count !== 16'd0) begin errors++; $display("FAIL prio_count: got %0d expected 0", move_count); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_held_busy: got %b expected 0", busy); end
    instruction = 4'd0; scramble = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation;
    pulse(4'd3);
    force dut.mcnt = 16'hFFFE;
    #1 release dut.mcnt;
    pulse(4'd2);
    checks++; if (move_count !== 16'hFFFF) begin errors++; $display("FAIL sat_first: got %h expected ffff", move_count); end
    checks++; if (blank_pos !== 4'd15) begin errors++; $display("FAIL sat_blank: got %0d expected 15", blank_pos); end
    pulse(4'd3);
    checks++; if (move_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", move_count); end
    pulse(4'd4);
    checks++; if (blank_pos !== 4'd14) begin errors++; $display("FAIL south_edge_blank: got %0d expected 14", blank_pos); end
  endtask

  task automatic test_reset_mid_scramble;
    pulse(4'd5);
    @(negedge clk) scramble = 1'b1;
    repeat (10) @(negedge clk);
    scramble = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (blank_pos !== 4'd15) begin errors++; $display("FAIL rst_mid_blank: got %0d expected 15", blank_pos); end
    read_board(brd);
    checks++; if (brd !== solved_pat) begin errors++; $display("FAIL rst_mid_board: got %h expected %h", brd, solved_pat); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++; if (solved !== 1'b1) begin errors++; $display("FAIL rst_mid_solved: got %b expected 1", solved); end
  endtask

  initial begin
    test_reset;
    test_illegal_east;
    test_held_west;
    test_restart;
    test_directions;
    test_restart;
    test_scramble;
    test_scramble_abort;
    test_restart_beats_scramble;
    test_saturation;
    test_reset_mid_scramble;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
